// File: rtl/clock_set_port.sv
// clock_set_port: Avalon-MM output port that carries a new time value to the
// clock-counter core. The CPU loads a shadow DATA register and issues START.
// The block then presents the value on out_port and runs a four-phase
// set_req/set_ack handshake. A timeout aborts the handshake, and the sticky
// done/tmo flags report the outcome.
module clock_set_port #(
    parameter int DATA_WIDTH = 14,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  set_req,
    input  logic                  set_ack,
    output logic                  irq
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]            state;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  ie;
    logic                  done;
    logic                  tmo;
    logic                  busy;
    logic                  wr_en;
    logic                  wr_data;
    logic                  wr_ctrl;
    logic                  wr_clear;
    logic                  start;
    logic                  done_set;
    logic                  tmo_set;
    logic [31:0]           rd_mux;
    logic                  unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign wr_data  = wr_en & (address == 2'd0);
    assign wr_ctrl  = wr_en & (address == 2'd1);
    assign wr_clear = wr_en & (address == 2'd2);
    assign start    = wr_ctrl & writedata[0];
    assign busy     = (state != ST_IDLE);

    // Handshake completion and timeout are single-cycle pulses into the flags
    assign done_set = (state == ST_RELEASE) & ~set_ack;
    assign tmo_set  = (state == ST_REQ) & ~set_ack & (timer == TIMER_LAST);

    assign unused_wdata = ^writedata;

    // Handshake FSM: out_port loads only on an accepted START
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            out_port <= '0;
            set_req  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        out_port <= data_reg;
                        timer    <= '0;
                        set_req  <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (set_ack) begin
                        set_req <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (timer == TIMER_LAST) begin
                        set_req <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!set_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    set_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // CPU-visible registers; a hardware flag set overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            ie       <= 1'b0;
            done     <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            if (wr_data) begin
                data_reg <= writedata[DATA_WIDTH-1:0];
            end
            if (wr_ctrl) begin
                ie <= writedata[1];
            end
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_clear && writedata[1]) begin
                done <= 1'b0;
            end
            if (tmo_set) begin
                tmo <= 1'b1;
            end else if (wr_clear && writedata[2]) begin
                tmo <= 1'b0;
            end
        end
    end

    // Read mux, decoded on address alone
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(data_reg);
            2'd1:    rd_mux = {28'd0, ie, tmo, done, busy};
            default: rd_mux = '0;
        endcase
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= ie & (done | tmo);
        end
    end

endmodule

// File: tb/tb_clock_set_port.sv
// Directed bench for clock_set_port with a transaction-level reference model
// compared against the DUT outputs on every falling edge.
module tb_clock_set_port;

    localparam int DW  = 14;
    localparam int TMO = 8;

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          set_req;
    logic          set_ack;
    logic          irq;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    clock_set_port #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .set_req    (set_req),
        .set_ack    (set_ack),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = request outstanding, 2 = awaiting ack release
    int unsigned   cyc_no;
    int unsigned   req_start;
    int            phase;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_out;
    logic          m_ie, m_done, m_tmo, m_req, m_irq;
    logic [31:0]   m_rd;

    always @(posedge clk or negedge reset_n) begin
        bit wr, hw_done, hw_tmo;
        if (!reset_n) begin
            cyc_no = 0; req_start = 0; phase = 0;
            m_data = '0; m_out = '0; m_ie = 0; m_done = 0; m_tmo = 0;
            m_req = 0; m_irq = 0; m_rd = '0;
        end else begin
            cyc_no++;
            wr = chipselect && !write_n;
            if (address == 2'd0)      m_rd = 32'(m_data);
            else if (address == 2'd1) m_rd = 32'({m_ie, m_tmo, m_done, phase != 0});
            else                      m_rd = '0;
            m_irq = m_ie && (m_done || m_tmo);
            hw_done = 0;
            hw_tmo  = 0;
            if (phase == 0) begin
                if (wr && address == 2'd1 && writedata[0]) begin
                    m_out = m_data; m_req = 1; phase = 1; req_start = cyc_no;
                end
            end else if (phase == 1) begin
                if (set_ack) begin
                    m_req = 0; phase = 2;
                end else if (cyc_no - req_start == TMO) begin
                    m_req = 0; hw_tmo = 1; phase = 0;
                end
            end else begin
                if (!set_ack) begin
                    hw_done = 1; phase = 0;
                end
            end
            if (wr && address == 2'd0) m_data = writedata[DW-1:0];
            if (wr && address == 2'd1) m_ie = writedata[1];
            if (wr && address == 2'd2 && writedata[1]) m_done = 0;
            if (wr && address == 2'd2 && writedata[2]) m_tmo = 0;
            if (hw_done) m_done = 1;
            if (hw_tmo)  m_tmo = 1;
        end
    end

    // Cycle-by-cycle comparison of all outputs
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (readdata !== m_rd) begin
                errors++;
                $display("FAIL model_readdata t=%0t got=%h want=%h", $time, readdata, m_rd);
            end
            checks++;
            if (out_port !== m_out) begin
                errors++;
                $display("FAIL model_out_port t=%0t got=%h want=%h", $time, out_port, m_out);
            end
            checks++;
            if (set_req !== m_req) begin
                errors++;
                $display("FAIL model_set_req t=%0t got=%b want=%b", $time, set_req, m_req);
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL model_irq t=%0t got=%b want=%b", $time, irq, m_irq);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic wait_req_low(input int maxc);
        int n;
        n = 0;
        while (set_req && n < maxc) begin
            cyc();
            n++;
        end
        chk("req_low_bound", 32'(set_req), 32'd0);
    endtask

    initial begin
        int cnt;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        set_ack    = 1'b0;
        repeat (3) cyc();
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_out_port", 32'(out_port), 32'd0);
        chk("rst_set_req", 32'(set_req), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // All registers read zero after reset
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            cyc();
            chk("rst_read_addr", readdata, 32'd0);
        end

        // DATA write is visible on read but not on out_port
        do_write(2'd0, 32'h0000_2A5B);
        cyc();
        chk("data_read", readdata, 32'h0000_2A5B);
        chk("data_no_start", 32'(out_port), 32'd0);

        // Normal transfer with delayed ack
        do_write(2'd0, 32'h0000_1234);
        do_write(2'd1, 32'h3);
        chk("xfer_out_port", 32'(out_port), 32'h1234);
        chk("xfer_req_rise", 32'(set_req), 32'd1);
        address = 2'd1;
        cyc();
        chk("xfer_busy", readdata, 32'h9);
        cyc();
        cyc();
        set_ack = 1'b1;
        wait_req_low(20);
        cyc();
        cyc();
        set_ack = 1'b0;
        cyc();
        cyc();
        chk("xfer_ctrl_done", readdata, 32'hA);
        chk("xfer_irq", 32'(irq), 32'd1);
        do_write(2'd2, 32'h6);

        // Timeout with ack never arriving
        do_write(2'd1, 32'h1);
        cnt = set_req ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!set_req) break;
            cnt++;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'd8);
        cyc();
        chk("tmo_ctrl", readdata, 32'h4);
        do_write(2'd2, 32'h4);

        // DATA write and second START during a transfer
        do_write(2'd1, 32'h3);
        do_write(2'd0, 32'h0000_0111);
        do_write(2'd1, 32'h3);
        chk("ovl_out_hold", 32'(out_port), 32'h1234);
        chk("ovl_req_held", 32'(set_req), 32'd1);
        set_ack = 1'b1;
        wait_req_low(20);
        set_ack = 1'b0;
        cyc();
        do_write(2'd2, 32'h6);
        do_write(2'd1, 32'h3);
        chk("ovl_new_out", 32'(out_port), 32'h0111);
        set_ack = 1'b1;
        cyc();
        chk("ovl_req_fall", 32'(set_req), 32'd0);
        set_ack = 1'b0;
        // CLEAR lands on the same edge that sets done
        do_write(2'd2, 32'h6);
        address = 2'd1;
        cyc();
        chk("clr_race_done", readdata, 32'hA);
        do_write(2'd2, 32'h6);
        address = 2'd1;
        cyc();
        chk("clr_ctrl", readdata, 32'h8);
        chk("clr_irq", 32'(irq), 32'd0);

        // Ack already high when the request starts
        set_ack = 1'b1;
        do_write(2'd1, 32'h1);
        cyc();
        chk("early_ack_req", 32'(set_req), 32'd0);
        set_ack = 1'b0;
        cyc();
        do_write(2'd2, 32'h2);

        // Reset in the middle of a request
        do_write(2'd1, 32'h1);
        cyc();
        chk("mid_req_high", 32'(set_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(set_req), 32'd0);
        chk("mid_rst_out", 32'(out_port), 32'd0);
        cyc();
        reset_n = 1'b1;
        address = 2'd1;
        cyc();
        chk("mid_rst_ctrl", readdata, 32'd0);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clock_set_port.md
Name: clock_set_port

Overview:
- Avalon-MM slave output port that carries a new time value from the Nios CPU to the clock-counter hardware. It is the write-direction companion of the clock read-back input port.
- CPU writes a 14-bit value into a shadow register, then issues a start command.
- Block presents the value on out_port and runs a four-phase req/ack handshake with the clock core, with timeout and sticky status flags.

Parameters:
- DATA_WIDTH, 14, width of shadow register and out_port.
- TIMEOUT, 1023, cycles in REQ without set_ack before abort; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low; write when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered, one-cycle latency.
- out_port  out  DATA_WIDTH  value presented to clock core.
- set_req  out  1  handshake request to clock core.
- set_ack  in  1  handshake acknowledge from clock core, synchronous to clk.
- irq  out  1  interrupt, level.

Behaviour:
- Reset (async, reset_n=0):
  - readdata=0, out_port=0, set_req=0, irq=0.
  - data_reg=0, ie=0, done=0, tmo=0, timer=0, FSM=IDLE.
- Register map:
  - addr0 DATA: write stores writedata[DATA_WIDTH-1:0] in data_reg; read returns data_reg zero-extended.
  - addr1 CTRL: write bit0=1 is START; bit1 is written into ie. Read returns {28'b0, ie, tmo, done, busy}, where busy = (FSM != IDLE).
  - addr2 CLEAR: write 1 to bit1 clears done, write 1 to bit2 clears tmo. Reads 0.
  - addr3: reserved; writes ignored, reads 0.
- Reads:
  - readdata updates every cycle from the mux on the current address, regardless of chipselect.
  - Value is visible the cycle after the address is presented.
- FSM:
  - IDLE:
    - START write -> out_port<=data_reg, timer<=0, set_req<=1, go REQ.
    - START while not IDLE is ignored; no error flag.
  - REQ:
    - set_req=1.
    - set_ack=1 -> set_req<=0, go RELEASE.
    - Else timer increments.
    - timer==TIMEOUT-1 with no ack -> set_req<=0, tmo<=1, go IDLE; done stays unchanged.
  - RELEASE:
    - set_req=0, wait for set_ack=0, then done<=1 and go IDLE.
    - No timeout in RELEASE.
- out_port:
  - Loads only on accepted START.
  - Holds its value otherwise, including after completion or timeout.
  - Writes to DATA during a transfer update data_reg only; out_port stays stable.
- Timing:
  - set_req rises the cycle after the START write.
  - set_req falls the cycle after set_ack is sampled high.
  - done sets the cycle after set_ack is sampled low.
- Simultaneous events:
  - Hardware set of done/tmo in the same cycle as a CLEAR write of that bit: set wins.
  - set_ack already high when REQ is entered: accepted on the first REQ cycle.
- irq = ie & (done | tmo), registered.
- Reset mid-transfer: all state returns to reset values immediately; set_req drops asynchronously.

Test Plan:
- Reset then read addr0..3 -> readdata=0 for each; out_port=0, set_req=0.
- Write DATA=0x2A5B, then read addr0 -> 0x00002A5B. out_port stays 0 (no START).
- Write DATA=0x1234, write CTRL=0x3, set_ack responds 3 cycles after set_req and drops 2 cycles after set_req falls:
  - out_port=0x1234 and set_req=1 the cycle after the write.
  - CTRL read shows busy=1 during transfer, then 0x0000000A (ie, done) after.
  - irq=1.
- Timeout: TIMEOUT=8, START with set_ack held 0:
  - set_req high exactly 8 cycles, then 0.
  - CTRL read = 0x00000004; done=0.
- Write DATA=0x0111 and START during a transfer of 0x1234:
  - out_port stays 0x1234; second START ignored.
  - After completion, new START drives 0x0111.
- Edge cases:
  - CLEAR write 0x6 in the same cycle done sets -> done=1.
  - Next CLEAR 0x6 -> done=0, tmo=0, irq=0.
  - Assert reset_n=0 during REQ -> set_req=0 immediately, CTRL reads 0.
